// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Multi-cycle issue/writeback controller that feeds a combinational ALU.
// An instruction is accepted in IDLE, decoded (operands read from the
// internal register file or taken from the sign-extended immediate),
// presented to the ALU for ALU_LAT cycles, then the sampled result is
// written back and done pulses.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   instr_valid/instr     instruction handshake input (32-bit word)
//   instr_ready           high while the controller is idle
//   alu_in1/alu_in2       ALU operands, held stable through EXEC
//   alu_shamt/alu_func    ALU shift amount and function code
//   alu_out/alu_flags     ALU result and flags, sampled at end of EXEC
//   done/done_flags       writeback pulse and flags of the last op
//   illegal               pulse in DECODE when func > MAX_FUNC
//   dbg_addr/dbg_data     combinational register-file debug read
//   sticky_flags          OR of all written-back flags
//
// Optional feature macro: STICKY_FLAGS_EN (undefined => sticky_flags = 0).

module alu_issue_ctrl #(
    parameter int ALU_LAT  = 1,
    parameter int REG_AW   = 3,
    parameter int MAX_FUNC = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [31:0]       alu_in1,
    output logic [31:0]       alu_in2,
    output logic              alu_shamt,
    output logic [3:0]        alu_func,
    input  logic [31:0]       alu_out,
    input  logic [2:0]        alu_flags,
    output logic              done,
    output logic [2:0]        done_flags,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [2:0]        sticky_flags
);

    localparam int         NREGS    = 2 ** REG_AW;
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);
    localparam logic [4:0] FUNC_MAX = 5'(MAX_FUNC);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t            state, next_state;
    logic [31:0]       instr_q;
    logic [31:0]       result_q;
    logic [2:0]        flags_q;
    logic [3:0]        count;
    logic [31:0]       regs [NREGS];

    logic [3:0]        f_func;
    logic [REG_AW-1:0] f_rd, f_rs, f_rt;
    logic              f_use_imm, f_shamt;
    logic [31:0]       f_imm;
    logic              illegal_op;

    // Field extraction from the latched word; narrower register files use
    // only the low bits of each 3-bit address field.
    assign f_func     = instr_q[31:28];
    assign f_rd       = instr_q[25 +: REG_AW];
    assign f_rs       = instr_q[22 +: REG_AW];
    assign f_rt       = instr_q[19 +: REG_AW];
    assign f_use_imm  = instr_q[18];
    assign f_shamt    = instr_q[17];
    assign f_imm      = {{15{instr_q[16]}}, instr_q[16:0]};
    assign illegal_op = {1'b0, f_func} > FUNC_MAX;

    // r0 is never written, so it keeps its reset value of zero.
    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (instr_valid) next_state = DECODE;
            DECODE:  next_state = illegal_op ? IDLE : EXEC;
            EXEC:    if (count == 4'd0) next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        illegal     = (state == DECODE) && illegal_op;
    end

    // Datapath. Writeback happens on the edge leaving WB, so done is seen in
    // the first IDLE cycle and a following DECODE already reads the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            count      <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_shamt  <= 1'b0;
            alu_func   <= '0;
            done       <= 1'b0;
            done_flags <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) instr_q <= instr;
                end
                DECODE: begin
                    if (!illegal_op) begin
                        alu_in1   <= regs[f_rs];
                        alu_in2   <= f_use_imm ? f_imm : regs[f_rt];
                        alu_shamt <= f_shamt;
                        alu_func  <= f_func;
                        count     <= LAT_INIT;
                    end
                end
                EXEC: begin
                    if (count == 4'd0) begin
                        result_q <= alu_out;
                        flags_q  <= alu_flags;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                WB: begin
                    if (f_rd != '0) regs[f_rd] <= result_q;
                    done_flags <= flags_q;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef STICKY_FLAGS_EN
    // Accumulates flags of every completed op; illegal ops never reach WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sticky_flags <= '0;
        else if (state == WB) sticky_flags <= sticky_flags | flags_q;
    end
`else
    assign sticky_flags = 3'b000;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand-written
// back-to-back and reset sequences, and randomized instructions checked
// against a register-array reference model. A behavioural ALU drives alu_out.

module tb_alu_issue_ctrl;

    parameter int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_shamt;
    logic [3:0]  alu_func;
    logic [2:0]  alu_flags;
    logic        done, illegal;
    logic [2:0]  done_flags, sticky_flags;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] w;
        logic [31:0] in1, in2;
        logic [3:0]  func;
        logic        shamt;
        logic [31:0] val;
        logic [2:0]  flags;
        logic        ill;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] model_regs [8];
    logic [31:0] last_in1, last_in2;
    logic [3:0]  last_func;
    logic        last_shamt;
    logic [2:0]  sticky_acc;

    alu_issue_ctrl #(.ALU_LAT(LAT), .REG_AW(3), .MAX_FUNC(9)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_shamt(alu_shamt), .alu_func(alu_func), .alu_out(alu_out),
        .alu_flags(alu_flags), .done(done), .done_flags(done_flags),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic sh);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a << sh;
            4'd7: return a >> sh;
            4'd8: return 32'($signed(a) >>> sh);
            4'd9: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] flags_of(input logic [31:0] r);
        return {r[31], r == 32'd0, r[0]};
    endfunction

    always_comb begin
        alu_out   = alu_ref(alu_func, alu_in1, alu_in2, alu_shamt);
        alu_flags = flags_of(alu_out);
    end

    function automatic logic [31:0] mk(input int f, input int rd, input int rs, input int rt,
                                       input int ui, input int sh, input int imm);
        return {4'(f), 3'(rd), 3'(rs), 3'(rt), 1'(ui), 1'(sh), 17'(imm)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [2:0] sticky_want();
`ifdef STICKY_FLAGS_EN
        return sticky_acc;
`else
        return 3'b000;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_regs[i] = 32'd0;
        last_in1 = 0; last_in2 = 0; last_func = 0; last_shamt = 0; sticky_acc = 0;
    endtask

    // Reference model: what the instruction should do given the architectural
    // register contents; updates the model as if the instruction retired.
    task automatic predict(input logic [31:0] w, output vec_t v);
        logic [2:0] rd, rs, rt;
        rd = w[27:25]; rs = w[24:22]; rt = w[21:19];
        v.name = "rand";
        v.w    = w;
        v.ill  = (w[31:28] > 4'd9);
        if (v.ill) begin
            v.in1 = last_in1; v.in2 = last_in2; v.func = last_func; v.shamt = last_shamt;
            v.val = model_regs[rd]; v.flags = 3'b000;
        end else begin
            v.in1   = model_regs[rs];
            v.in2   = w[18] ? {{15{w[16]}}, w[16:0]} : model_regs[rt];
            v.func  = w[31:28];
            v.shamt = w[17];
            v.val   = alu_ref(v.func, v.in1, v.in2, v.shamt);
            v.flags = flags_of(v.val);
            last_in1 = v.in1; last_in2 = v.in2; last_func = v.func; last_shamt = v.shamt;
            sticky_acc = sticky_acc | v.flags;
            if (rd != 3'd0) model_regs[rd] = v.val;
        end
    endtask

    task automatic apply_instr(input vec_t v, input bit noise);
        int n;
        logic [2:0] rd;
        rd = v.w[27:25];
        @(negedge clk);
        check({v.name, " ready_idle"}, instr_ready, 1);
        instr = v.w; instr_valid = 1'b1; dbg_addr = rd;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = $urandom;
        @(negedge clk);
        check({v.name, " illegal"}, illegal, v.ill);
        check({v.name, " ready_busy"}, instr_ready, 0);
        if (v.ill) begin
            @(negedge clk);
            check({v.name, " ill_ready"}, instr_ready, 1);
            check({v.name, " ill_pulse"}, illegal, 0);
            check({v.name, " ill_done"}, done, 0);
            check({v.name, " ill_in1"}, alu_in1, v.in1);
            check({v.name, " ill_in2"}, alu_in2, v.in2);
            check({v.name, " ill_func"}, alu_func, v.func);
            check({v.name, " ill_reg"}, dbg_data, v.val);
        end else begin
            // Optional noise: valid raised while busy must be ignored.
            if (noise) begin instr_valid = 1'b1; instr = $urandom; end
            n = 0;
            while (done !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
                if (n <= LAT) begin
                    check({v.name, " in1"}, alu_in1, v.in1);
                    check({v.name, " in2"}, alu_in2, v.in2);
                    check({v.name, " func"}, alu_func, v.func);
                    check({v.name, " shamt"}, alu_shamt, v.shamt);
                end
                if (n == LAT + 1) instr_valid = 1'b0;
            end
            instr_valid = 1'b0;
            check({v.name, " done_latency"}, n, 2 + LAT);
            check({v.name, " done_flags"}, done_flags, v.flags);
            check({v.name, " wb_reg"}, dbg_data, (rd == 3'd0) ? 32'd0 : v.val);
            check({v.name, " sticky"}, sticky_flags, sticky_want());
            @(negedge clk);
            check({v.name, " done_pulse"}, done, 0);
        end
    endtask

    initial begin
        vec_t v;
        int n, low, dones;
        logic [31:0] wa, wb;

        vecs[0] = '{"imm_neg",  mk(0,1,0,0,1,0,-123),     32'h0, 32'hFFFFFF85, 4'd0, 1'b0, 32'hFFFFFF85, 3'b101, 1'b0};
        vecs[1] = '{"load_r2",  mk(0,2,0,0,1,0,456),      32'h0, 32'h1C8,      4'd0, 1'b0, 32'h1C8,      3'b000, 1'b0};
        vecs[2] = '{"add_rr",   mk(0,3,1,2,0,0,0),        32'hFFFFFF85, 32'h1C8, 4'd0, 1'b0, 32'h14D,    3'b001, 1'b0};
        vecs[3] = '{"shl1",     mk(6,4,2,0,0,1,0),        32'h1C8, 32'h0,      4'd6, 1'b1, 32'h390,      3'b000, 1'b0};
        vecs[4] = '{"wr_r0",    mk(1,0,3,1,0,0,0),        32'h14D, 32'hFFFFFF85, 4'd1, 1'b0, 32'h1C8,    3'b000, 1'b0};
        vecs[5] = '{"ill_10",   mk(10,5,3,0,1,0,7),       32'h14D, 32'hFFFFFF85, 4'd1, 1'b0, 32'h0,      3'b000, 1'b1};
        vecs[6] = '{"ill_15",   mk(15,1,2,2,0,1,0),       32'h14D, 32'hFFFFFF85, 4'd1, 1'b0, 32'hFFFFFF85, 3'b000, 1'b1};
        vecs[7] = '{"and_m1",   mk(2,5,3,0,1,0,32'h1FFFF), 32'h14D, 32'hFFFFFFFF, 4'd2, 1'b0, 32'h14D,   3'b001, 1'b0};
        vecs[8] = '{"func_max", mk(9,6,0,0,1,0,32'h10000), 32'h0, 32'hFFFF0000, 4'd9, 1'b0, 32'hFFFF0000, 3'b100, 1'b0};
        vecs[9] = '{"shr1",     mk(7,7,6,0,1,1,0),        32'hFFFF0000, 32'h0, 4'd7, 1'b1, 32'h7FFF8000, 3'b000, 1'b0};

        model_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 3'd0;
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_in1", alu_in1, 0);
        check("rst_in2", alu_in2, 0);
        check("rst_func", alu_func, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_done_flags", done_flags, 0);
        check("rst_sticky", sticky_flags, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            predict(vecs[i].w, v);
            apply_instr(vecs[i], 1'b0);
        end
        dbg_addr = 3'd0; #1;
        check("r0_zero", dbg_data, 0);

        $display("[TB] back-to-back with instr_valid held high");
        wa = mk(0,1,0,0,1,0,1000);
        wb = mk(0,2,1,0,1,0,5);
        predict(wa, v);
        predict(wb, v);
        @(negedge clk);
        instr = wa; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = wb;
        n = 0; low = 0;
        do begin
            @(negedge clk);
            n++;
            if (!instr_ready) low++;
        end while (done !== 1'b1 && n < 40);
        check("b2b_done_latency", n - 1, 2 + LAT);
        check("b2b_ready_low", low, 2 + LAT);
        dbg_addr = 3'd1; #1;
        check("b2b_first_wb", dbg_data, 32'd1000);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        check("b2b2_done_latency", n - 1, 2 + LAT);
        dbg_addr = 3'd2; #1;
        check("b2b_forward", dbg_data, 32'd1005);
        check("b2b_done_flags", done_flags, 3'b001);
        check("b2b_sticky", sticky_flags, sticky_want());

        $display("[TB] randomized instructions");
        for (int i = 0; i < 40; i++) begin
            predict($urandom, v);
            apply_instr(v, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            check("rand_regfile", dbg_data, model_regs[a]);
        end

        $display("[TB] reset during writeback");
        wa = mk(0,3,0,0,1,0,77);
        dbg_addr = 3'd3;
        @(negedge clk);
        instr = wa; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_in1", alu_in1, 0);
        check("arst_in2", alu_in2, 0);
        check("arst_func", alu_func, 0);
        check("arst_shamt", alu_shamt, 0);
        check("arst_done_flags", done_flags, 0);
        check("arst_sticky", sticky_flags, 0);
        check("arst_ready", instr_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("arst_no_done", dones, 0);
        check("arst_no_write", dbg_data, 0);

        $display("[TB] sticky flag accumulation");
        predict(mk(0,1,0,0,1,0,1), v);
        v.name = "flag001";
        apply_instr(v, 1'b0);
        predict(mk(0,2,0,0,1,0,-2), v);
        v.name = "flag100";
        apply_instr(v, 1'b0);
`ifdef STICKY_FLAGS_EN
        check("sticky_101", sticky_flags, 3'b101);
`else
        check("sticky_off", sticky_flags, 3'b000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
